pattern_ram_writer: RTL and testbench

//  Parametrised test-pattern source for the line-buffer RAM feeding the VGA scan-out.

---
 rtl/vga_pattern_pkg.sv | 20 ++
 rtl/pattern_row_gen.sv | 71 +++++++
 rtl/pattern_ram_writer.sv | 143 ++++++++++++++
 tb/tb_pattern_ram_writer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg
//   Shared definitions for the line-buffer test-pattern writer:
//   3-bit pattern mode codes and the writer FSM state encoding.
package vga_pattern_pkg;

    localparam logic [2:0] MODE_ALT     = 3'd0;
    localparam logic [2:0] MODE_SOLID   = 3'd1;
    localparam logic [2:0] MODE_CHECKER = 3'd2;
    localparam logic [2:0] MODE_HBARS   = 3'd3;
    localparam logic [2:0] MODE_VSTRIPE = 3'd4;
    localparam logic [2:0] MODE_ROWNUM  = 3'd5;
    localparam logic [2:0] MODE_SCROLL  = 3'd6;
    localparam logic [2:0] MODE_BLANK   = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/pattern_row_gen.sv
// pattern_row_gen
//   Combinational row-word generator: produces one ROW_BITS-wide 1 bpp row
//   for a given pattern mode, row index and scroll phase.
// Ports
//   mode   in   3         pattern select (MODE_* codes)
//   row    in   ADDR_W    row index the word is for
//   phase  in   PHASE_W   scroll phase (only used by MODE_SCROLL)
//   word   out  ROW_BITS  row pixels; bit i = pixel column i
module pattern_row_gen
    import vga_pattern_pkg::*;
#(
    parameter int ROW_BITS = 320,
    parameter int ADDR_W   = 8,
    parameter int PHASE_W  = 4
) (
    input  logic [2:0]          mode,
    input  logic [ADDR_W-1:0]   row,
    input  logic [PHASE_W-1:0]  phase,
    output logic [ROW_BITS-1:0] word
);

    logic [3:0] phase_lo;
    logic       row_b3;
    logic       row_b4;

    // Only bit 3 of (column + phase) matters, so a 4-bit sum is enough.
    assign phase_lo = 4'(phase);

    // Small builds may have fewer than 5 address bits; missing row bits read as 0.
    if (ADDR_W > 3) begin : g_rb3
        assign row_b3 = row[3];
    end else begin : g_rb3_zero
        assign row_b3 = 1'b0;
    end

    if (ADDR_W > 4) begin : g_rb4
        assign row_b4 = row[4];
    end else begin : g_rb4_zero
        assign row_b4 = 1'b0;
    end

    for (genvar c = 0; c < ROW_BITS; c++) begin : g_col
        localparam logic [4:0] COL = 5'(c % 32);
        logic rownum_bit;
        logic pix;

        if (c < ADDR_W) begin : g_rn
            assign rownum_bit = row[c];
        end else begin : g_rn_zero
            assign rownum_bit = 1'b0;
        end

        always_comb begin
            case (mode)
                MODE_ALT:     pix = COL[0];
                MODE_SOLID:   pix = 1'b1;
                MODE_CHECKER: pix = COL[3] ^ row_b3;
                MODE_HBARS:   pix = row_b4;
                MODE_VSTRIPE: pix = COL[4];
                MODE_ROWNUM:  pix = rownum_bit;
                // 4-bit add wraps mod 16, so ">= 8" is exactly bit 3 of the sum.
                MODE_SCROLL:  pix = ((COL[3:0] + phase_lo) >= 4'd8) ^ row_b3;
                MODE_BLANK:   pix = 1'b0;
                default:      pix = 1'b0;
            endcase
        end

        assign word[c] = pix;
    end

endmodule

// File: rtl/pattern_ram_writer.sv
// pattern_ram_writer
//   Test-pattern source for the line-buffer RAM feeding VGA scan-out.
//   Fills ROWS rows with a selectable pattern, once per start or
//   continuously, honouring write backpressure (ram_ready).
// Ports
//   clk          in   1         system clock
//   rst          in   1         synchronous active-high reset
//   start        in   1         pulse: begin a frame fill (ignored while busy)
//   continuous   in   1         restart at row 0 after last row (sampled at frame start)
//   mode         in   3         pattern select (latched at frame start)
//   ram_ready    in   1         sink accepts the presented write this cycle
//   ram_clk      out  1         clk pass-through
//   ram_we       out  1         write request
//   ram_address  out  ADDR_W    row being written
//   ram_data     out  ROW_BITS  row pixels, LSB = column 0
//   busy         out  1         frame fill in progress
//   frame_done   out  1         one-cycle pulse after last row accepted
module pattern_ram_writer
    import vga_pattern_pkg::*;
#(
    parameter int ROW_BITS = 320,
    parameter int ROWS     = 240,
    parameter int ADDR_W   = 8,
    parameter int PHASE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic [2:0]          mode,
    input  logic                ram_ready,
    output logic                ram_clk,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [ROW_BITS-1:0] ram_data,
    output logic                busy,
    output logic                frame_done
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_t               state;
    logic [2:0]           mode_q;
    logic                 cont_q;
    logic [PHASE_W-1:0]   phase;

    logic                 accept;
    logic                 last_accept;
    logic [2:0]           gen_mode;
    logic [ADDR_W-1:0]    gen_row;
    logic [PHASE_W-1:0]   gen_phase;
    logic [ROW_BITS-1:0]  gen_word;

    assign ram_clk     = clk;
    assign accept      = ram_we & ram_ready;
    assign last_accept = accept && (ram_address == LAST_ROW);

    // Generator inputs describe the row that will be presented next cycle.
    // A new frame (from IDLE or a continuous wrap) uses the live mode input
    // and row 0; the wrap also sees the already-advanced phase.
    always_comb begin
        gen_mode  = mode_q;
        gen_row   = ram_address + ADDR_W'(1);
        gen_phase = phase;
        if (state == ST_IDLE) begin
            gen_mode = mode;
            gen_row  = '0;
        end else if (last_accept) begin
            gen_mode  = mode;
            gen_row   = '0;
            gen_phase = phase + PHASE_W'(1);
        end
    end

    pattern_row_gen #(
        .ROW_BITS (ROW_BITS),
        .ADDR_W   (ADDR_W),
        .PHASE_W  (PHASE_W)
    ) u_row_gen (
        .mode  (gen_mode),
        .row   (gen_row),
        .phase (gen_phase),
        .word  (gen_word)
    );

    // ---- output register stage: address and data registered together ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            phase       <= '0;
            mode_q      <= MODE_ALT;
            cont_q      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_WRITE;
                        ram_we      <= 1'b1;
                        busy        <= 1'b1;
                        ram_address <= '0;
                        ram_data    <= gen_word;
                        mode_q      <= mode;
                        cont_q      <= continuous;
                    end
                end
                ST_WRITE: begin
                    // Without an accept everything holds, so no row is skipped.
                    if (accept) begin
                        if (ram_address == LAST_ROW) begin
                            frame_done <= 1'b1;
                            phase      <= phase + PHASE_W'(1);
                            if (cont_q) begin
                                ram_address <= '0;
                                ram_data    <= gen_word;
                                mode_q      <= mode;
                                cont_q      <= continuous;
                            end else begin
                                state  <= ST_IDLE;
                                ram_we <= 1'b0;
                                busy   <= 1'b0;
                            end
                        end else begin
                            ram_address <= ram_address + ADDR_W'(1);
                            ram_data    <= gen_word;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ram_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_ram_writer.sv
// tb_pattern_ram_writer
//   Scoreboard bench: stimulus pushes expected writes / frame_done cycles,
//   negedge monitors pop and compare whenever the DUTs present them.
//   A second, small instance (ROWS=4, ROW_BITS=16) covers the tiny build.
module tb_pattern_ram_writer;

    localparam int RB  = 320;
    localparam int NR  = 240;
    localparam int AW  = 8;
    localparam int SRB = 16;
    localparam int SNR = 4;
    localparam int SAW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, continuous, ram_ready;
    logic [2:0]     mode;
    logic           ram_clk, ram_we, busy, frame_done;
    logic [AW-1:0]  ram_address;
    logic [RB-1:0]  ram_data;

    logic           s_start, s_ready;
    logic [2:0]     s_mode;
    logic           s_ram_clk, s_we, s_busy, s_fd;
    logic [SAW-1:0] s_addr;
    logic [SRB-1:0] s_data;

    pattern_ram_writer #(.ROW_BITS(RB), .ROWS(NR), .ADDR_W(AW), .PHASE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mode(mode),
        .ram_ready(ram_ready), .ram_clk(ram_clk), .ram_we(ram_we),
        .ram_address(ram_address), .ram_data(ram_data), .busy(busy), .frame_done(frame_done)
    );

    pattern_ram_writer #(.ROW_BITS(SRB), .ROWS(SNR), .ADDR_W(SAW), .PHASE_W(4)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .continuous(1'b0), .mode(s_mode),
        .ram_ready(s_ready), .ram_clk(s_ram_clk), .ram_we(s_we),
        .ram_address(s_addr), .ram_data(s_data), .busy(s_busy), .frame_done(s_fd)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int ph    = 0;

    typedef struct { logic [AW-1:0]  addr; logic [RB-1:0]  data; } wr_t;
    typedef struct { logic [SAW-1:0] addr; logic [SRB-1:0] data; } swr_t;
    wr_t  exp_q[$];
    swr_t sexp_q[$];
    int   fd_q[$];
    int   sfd_q[$];

    wr_t  mon_e;
    swr_t mon_se;
    int   mon_fd;

    task automatic chk(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [RB-1:0] pat(input int m, input int r, input int p, input int aw);
        logic [RB-1:0] w;
        w = '0;
        for (int i = 0; i < RB; i++) begin
            case (m)
                0: w[i] = (i % 2) != 0;
                1: w[i] = 1'b1;
                2: w[i] = ((i / 8) % 2) != ((r / 8) % 2);
                3: w[i] = ((r / 16) % 2) != 0;
                4: w[i] = ((i / 16) % 2) != 0;
                5: w[i] = (i < aw) && (((r >> i) % 2) != 0);
                6: w[i] = (((i + p) / 8) % 2) != ((r / 8) % 2);
                default: w[i] = 1'b0;
            endcase
        end
        return w;
    endfunction

    task automatic push_row(input int r, input logic [RB-1:0] d);
        wr_t e;
        e.addr = AW'(r);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int m, input int p, input int fd_cyc);
        for (int r = 0; r < NR; r++) push_row(r, pat(m, r, p, AW));
        fd_q.push_back(fd_cyc);
    endtask

    task automatic push_small_frame(input logic [SRB-1:0] d, input int fd_cyc);
        swr_t e;
        for (int r = 0; r < SNR; r++) begin
            e.addr = SAW'(r);
            e.data = d;
            sexp_q.push_back(e);
        end
        sfd_q.push_back(fd_cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; start is sampled at the end of cycle k.
    task automatic start_big(input logic [2:0] m, input logic c, output int k);
        mode       = m;
        continuous = c;
        start      = 1'b1;
        k          = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fd_q.size() != 0 || sexp_q.size() != 0 ||
                sfd_q.size() != 0 || busy || s_busy) && n < 700) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 700) begin
            n_bad++;
            $display("FAIL drain_%s: got %0d pending writes after timeout, expected 0",
                     nm, exp_q.size() + sexp_q.size());
        end
    endtask

    // Main DUT monitor
    always @(negedge clk) begin
        if (!rst && ram_we && ram_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got write to addr %0d, expected none", ram_address);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", RB'(ram_address), RB'(mon_e.addr));
                chk($sformatf("wr_data_row%0d", mon_e.addr), ram_data, mon_e.data);
            end
        end
        if (!rst && frame_done === 1'b1) begin
            if (fd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_fd = fd_q.pop_front();
                chk("frame_done_cycle", RB'(cyc), RB'(mon_fd));
            end
        end
    end

    // Small DUT monitor
    always @(negedge clk) begin
        if (!rst && s_we && s_ready) begin
            if (sexp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL s_unexpected_write: got write to addr %0d, expected none", s_addr);
            end else begin
                mon_se = sexp_q.pop_front();
                chk("s_wr_addr", RB'(s_addr), RB'(mon_se.addr));
                chk("s_wr_data", RB'(s_data), RB'(mon_se.data));
            end
        end
        if (!rst && s_fd === 1'b1) begin
            if (sfd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL s_unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_fd = sfd_q.pop_front();
                chk("s_frame_done_cycle", RB'(cyc), RB'(mon_fd));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RB-1:0] alt_word;
        int k;
        alt_word = {160{2'b10}};

        rst = 1'b1; start = 1'b0; continuous = 1'b0; ram_ready = 1'b1; mode = 3'd0;
        s_start = 1'b0; s_ready = 1'b1; s_mode = 3'd0;
        repeat (3) tick();

        // Reset state
        chk("rst_we",   RB'(ram_we), '0);
        chk("rst_addr", RB'(ram_address), '0);
        chk("rst_data", ram_data, '0);
        chk("rst_busy", RB'(busy), '0);
        chk("rst_fd",   RB'(frame_done), '0);
        chk("rst_s_we", RB'(s_we), '0);
        chk("ram_clk",  RB'(ram_clk), RB'(1));
        chk("s_ram_clk", RB'(s_ram_clk), RB'(1));
        rst = 1'b0;
        tick();

        // 1: ALT single frame, ready tied high
        start_big(3'd0, 1'b0, k);
        for (int r = 0; r < NR; r++) push_row(r, alt_word);
        fd_q.push_back(k + 241);
        chk("t1_busy_high", RB'(busy), RB'(1));
        repeat (239) tick();
        chk("t1_last_addr", RB'(ram_address), RB'(239));
        tick();
        chk("t1_busy_low", RB'(busy), '0);
        chk("t1_we_low",   RB'(ram_we), '0);
        chk("t1_fd_high",  RB'(frame_done), RB'(1));
        drain("t1");
        ph = ph + 1;

        // 2: CHECKER with 3-cycle stall at row 5
        start_big(3'd2, 1'b0, k);
        push_frame(2, ph, k + 244);
        chk("t2_row0_lo16", RB'(ram_data[15:0]), RB'(16'hFF00));
        repeat (5) tick();
        chk("t2_addr5", RB'(ram_address), RB'(5));
        ram_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("t2_stall_addr", RB'(ram_address), RB'(5));
            chk("t2_stall_we", RB'(ram_we), RB'(1));
        end
        ram_ready = 1'b1;
        repeat (3) tick();
        chk("t2_row8_addr", RB'(ram_address), RB'(8));
        chk("t2_row8_lo16", RB'(ram_data[15:0]), RB'(16'h00FF));
        drain("t2");

        // 3: continuous SCROLL, two frames, phase advances at wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ph = 0;
        tick();
        start_big(3'd6, 1'b1, k);
        continuous = 1'b0;
        push_frame(6, 0, k + 241);
        push_frame(6, 1, k + 481);
        repeat (240) tick();
        chk("t3_wrap_we",   RB'(ram_we), RB'(1));
        chk("t3_wrap_addr", RB'(ram_address), '0);
        chk("t3_wrap_lo8",  RB'(ram_data[7:0]), RB'(8'h80));
        chk("t3_wrap_fd",   RB'(frame_done), RB'(1));
        chk("t3_wrap_busy", RB'(busy), RB'(1));
        drain("t3");
        ph = 2;

        // 4: reset mid-frame at row 100, then a fresh fill from row 0
        start_big(3'd1, 1'b0, k);
        for (int r = 0; r < 100; r++) push_row(r, pat(1, r, 0, AW));
        repeat (100) tick();
        chk("t4_addr100", RB'(ram_address), RB'(100));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ph = 0;
        chk("t4_we",   RB'(ram_we), '0);
        chk("t4_addr", RB'(ram_address), '0);
        chk("t4_data", ram_data, '0);
        chk("t4_busy", RB'(busy), '0);
        tick();
        chk("t4_no_write", RB'(ram_we), '0);
        start_big(3'd4, 1'b0, k);
        push_frame(4, ph, k + 241);
        drain("t4");
        ph = ph + 1;

        // 5: start and mode change mid-frame are ignored
        start_big(3'd3, 1'b0, k);
        push_frame(3, ph, k + 241);
        repeat (50) tick();
        start = 1'b1;
        mode  = 3'd5;
        tick();
        start = 1'b0;
        drain("t5a");
        ph = ph + 1;
        tick();
        chk("t5_no_restart", RB'(busy), '0);
        start_big(3'd5, 1'b0, k);
        push_frame(5, ph, k + 241);
        drain("t5b");
        ph = ph + 1;

        // 6: small build, HBARS then CHECKER
        s_mode  = 3'd3;
        s_start = 1'b1;
        k       = cyc;
        tick();
        s_start = 1'b0;
        push_small_frame(16'h0000, k + 5);
        chk("t6_s_busy", RB'(s_busy), RB'(1));
        drain("t6a");
        s_mode  = 3'd2;
        s_start = 1'b1;
        k       = cyc;
        tick();
        s_start = 1'b0;
        push_small_frame(16'hFF00, k + 5);
        drain("t6b");

        repeat (4) tick();
        chk("end_exp_q", RB'(exp_q.size() + sexp_q.size()), '0);
        chk("end_fd_q",  RB'(fd_q.size() + sfd_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
